// File: rtl/zone_pkg.sv
// Shared types and constants for the zone command sequencer.
package zone_pkg;

  localparam int ZONE_W       = 3;
  localparam int ZONE_COLS    = 4;
  localparam int ZONE_ROWS    = 2;
  localparam int ZONE_ROW_BIT = 2;
  localparam int STAB_W       = 4;
  localparam logic [STAB_W-1:0] STAB_MAX = 4'd15;

  typedef logic [ZONE_W-1:0] zone_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRACK     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  // States in which a move is outstanding or settling.
  function automatic logic state_busy(input state_t s);
    return (s == ST_ISSUE) || (s == ST_WAIT_DONE) || (s == ST_HOLDOFF);
  endfunction

endpackage

// File: rtl/frame_debounce.sv
// Tracks a per-frame classification value and pulses when it has been
// identical for THRESH consecutive accepted samples.
module frame_debounce
  import zone_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,        // drop the count (no evaluation this cycle)
  input  logic  restart,    // next good sample starts a fresh run
  input  logic  sample,     // one pulse per frame
  input  logic  sample_ok,  // frame qualifies for tracking
  input  zone_t value,
  output zone_t cand_nxt,   // candidate after this sample
  output logic  stable      // run length reaches THRESH on this sample
);

  localparam logic [STAB_W-1:0] THRESH_C = STAB_W'(THRESH);

  zone_t             cand_q, cand_d;
  logic [STAB_W-1:0] cnt_q, cnt_d;
  logic              load;

  // Next candidate / run length; saturates so a long run never wraps into a new pulse.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    load   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (sample) begin
      if (!sample_ok) begin
        cnt_d = '0;
      end else if (!restart && (value == cand_q)) begin
        cnt_d = (cnt_q == STAB_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cand_d = value;
        cnt_d  = 4'd1;
        load   = 1'b1;
      end
    end
    stable   = sample && sample_ok && !clr && (cnt_d == THRESH_C) &&
               (load || (cnt_d != cnt_q));
    cand_nxt = cand_d;
  end

  // Candidate and run-length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/zone_cmd_sequencer.sv
// Debounces classifier zones, issues one arm move per stable zone, then waits
// for completion (with timeout) and a frame hold-off before tracking again.
module zone_cmd_sequencer
  import zone_pkg::*;
#(
  parameter int STABLE_FRAMES  = 4,
  parameter int HOLDOFF_FRAMES = 8,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TO_W           = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  zone_in,
  input  logic        zone_vld,
  input  logic        blob_present,
  output logic        cmd_valid,
  output logic [2:0]  cmd_zone,
  input  logic        cmd_ready,
  input  logic        arm_done,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic [2:0]  last_zone,
  output logic        last_vld,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      HOLD_LAST = 8'(HOLDOFF_FRAMES);

  state_t          state_q, state_d;
  logic            cmd_valid_q, cmd_valid_d;
  zone_t           cmd_zone_q, cmd_zone_d;
  logic            err_q, err_d;
  zone_t           last_zone_q, last_zone_d;
  logic            last_vld_q, last_vld_d;
  logic            busy_q, busy_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;

  logic  db_clr, db_restart, stable;
  zone_t cand_nxt;

  // Debounce only runs in IDLE/TRACK; leaving TRACK on enable-low forgets the run.
  assign db_clr     = !((state_q == ST_IDLE) || (state_q == ST_TRACK)) ||
                      ((state_q == ST_TRACK) && !enable);
  assign db_restart = (state_q == ST_IDLE);

  frame_debounce #(.THRESH(STABLE_FRAMES)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .clr       (db_clr),
    .restart   (db_restart),
    .sample    (zone_vld),
    .sample_ok (blob_present & enable),
    .value     (zone_in),
    .cand_nxt  (cand_nxt),
    .stable    (stable)
  );

  // Next-state and registered-output computation for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_zone_d  = cmd_zone_q;
    err_d       = err_q;
    last_zone_d = last_zone_q;
    last_vld_d  = last_vld_q;
    to_cnt_d    = to_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (zone_vld && blob_present && enable) begin
          if (stable) begin
            state_d     = ST_ISSUE;
            cmd_valid_d = 1'b1;
            cmd_zone_d  = cand_nxt;
          end else begin
            state_d = ST_TRACK;
          end
        end
      end
      ST_TRACK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (zone_vld) begin
          if (!blob_present) begin
            state_d = ST_IDLE;
          end else if (stable && !(last_vld_q && (cand_nxt == last_zone_q))) begin
            state_d     = ST_ISSUE;
            cmd_valid_d = 1'b1;
            cmd_zone_d  = cand_nxt;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          last_zone_d = cmd_zone_q;
          last_vld_d  = 1'b1;
          to_cnt_d    = '0;
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (arm_done) begin
          hold_cnt_d = '0;
          state_d    = ST_HOLDOFF;
        end else if (to_cnt_q == TO_LAST) begin
          err_d      = 1'b1;
          hold_cnt_d = '0;
          state_d    = ST_HOLDOFF;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else if (zone_vld) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = state_busy(state_d);
  end

  // State and output registers; reset drops any offered command immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_zone_q  <= '0;
      err_q       <= 1'b0;
      last_zone_q <= '0;
      last_vld_q  <= 1'b0;
      busy_q      <= 1'b0;
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_zone_q  <= cmd_zone_d;
      err_q       <= err_d;
      last_zone_q <= last_zone_d;
      last_vld_q  <= last_vld_d;
      busy_q      <= busy_d;
      to_cnt_q    <= to_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_zone    = cmd_zone_q;
  assign timeout_err = err_q;
  assign last_zone   = last_zone_q;
  assign last_vld    = last_vld_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_zone_cmd_sequencer.sv
// Directed vector table plus hand-written sequences for zone_cmd_sequencer.
module tb_zone_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] zone_in;
  logic       zone_vld;
  logic       blob_present;
  logic       cmd_valid;
  logic [2:0] cmd_zone;
  logic       cmd_ready;
  logic       arm_done;
  logic       err_clr;
  logic       timeout_err;
  logic [2:0] last_zone;
  logic       last_vld;
  logic       busy;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  zone_cmd_sequencer #(
    .STABLE_FRAMES (4),
    .HOLDOFF_FRAMES(8),
    .TIMEOUT_CYCLES(100),
    .TO_W          (26)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .zone_in      (zone_in),
    .zone_vld     (zone_vld),
    .blob_present (blob_present),
    .cmd_valid    (cmd_valid),
    .cmd_zone     (cmd_zone),
    .cmd_ready    (cmd_ready),
    .arm_done     (arm_done),
    .err_clr      (err_clr),
    .timeout_err  (timeout_err),
    .last_zone    (last_zone),
    .last_vld     (last_vld),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [2:0] z;
    logic       blob;
    logic       en;
    logic       done;
    logic [2:0] es;
    logic       ev;
    logic [2:0] ez;
    logic [2:0] el;
    logic       elv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vld, input logic [2:0] z, input logic blob,
                     input logic en, input logic done, input logic [2:0] es,
                     input logic ev, input logic [2:0] ez, input logic [2:0] el,
                     input logic elv);
    vec_t v;
    v.vld = vld; v.z = z; v.blob = blob; v.en = en; v.done = done;
    v.es = es; v.ev = ev; v.ez = ez; v.el = el; v.elv = elv;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [2:0] z);
    zone_vld     = 1'b1;
    zone_in      = z;
    blob_present = 1'b1;
    step();
    zone_vld = 1'b0;
  endtask

  initial begin
    // Rows: vld zone blob en done | state valid cmd_zone last_zone last_vld
    add(1, 5, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 5, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 5, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 5, 1, 1, 0, 2, 1, 5, 0, 0);
    add(0, 0, 1, 1, 0, 3, 0, 5, 5, 1);
    add(0, 0, 1, 1, 0, 3, 0, 5, 5, 1);
    add(0, 0, 1, 1, 1, 4, 0, 5, 5, 1);
    for (int i = 0; i < 8; i++) add(1, 3, 1, 1, 0, 4, 0, 5, 5, 1);
    add(0, 0, 1, 1, 0, 0, 0, 5, 5, 1);
    add(1, 2, 1, 1, 0, 1, 0, 5, 5, 1);
    add(1, 2, 1, 1, 0, 1, 0, 5, 5, 1);
    add(1, 3, 1, 1, 0, 1, 0, 5, 5, 1);
    add(1, 3, 1, 1, 0, 1, 0, 5, 5, 1);
    add(1, 3, 1, 1, 0, 1, 0, 5, 5, 1);
    add(1, 3, 1, 1, 0, 2, 1, 3, 5, 1);
    add(0, 0, 1, 1, 0, 3, 0, 3, 3, 1);
    add(0, 0, 1, 1, 1, 4, 0, 3, 3, 1);
    for (int i = 0; i < 8; i++) add(1, 3, 1, 1, 0, 4, 0, 3, 3, 1);
    add(0, 0, 1, 1, 0, 0, 0, 3, 3, 1);
    add(1, 3, 1, 1, 0, 1, 0, 3, 3, 1);
    add(1, 3, 1, 1, 0, 1, 0, 3, 3, 1);
    add(1, 3, 1, 1, 0, 1, 0, 3, 3, 1);
    add(1, 3, 1, 1, 0, 1, 0, 3, 3, 1);
    add(0, 0, 1, 1, 0, 1, 0, 3, 3, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3, 3, 1);
    add(1, 3, 1, 1, 0, 1, 0, 3, 3, 1);
    add(1, 3, 0, 1, 0, 0, 0, 3, 3, 1);

    rst = 1'b1; enable = 1'b1; zone_in = '0; zone_vld = 1'b0;
    blob_present = 1'b0; cmd_ready = 1'b1; arm_done = 1'b0; err_clr = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset state", state_dbg, 0);
    chk("reset cmd_valid", cmd_valid, 0);
    chk("reset cmd_zone", cmd_zone, 0);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset last_zone", last_zone, 0);
    chk("reset last_vld", last_vld, 0);
    chk("reset busy", busy, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      zone_vld = vecs[i].vld; zone_in = vecs[i].z; blob_present = vecs[i].blob;
      enable = vecs[i].en; arm_done = vecs[i].done;
      step();
      chk($sformatf("row%0d state", i), state_dbg, vecs[i].es);
      chk($sformatf("row%0d cmd_valid", i), cmd_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("row%0d cmd_zone", i), cmd_zone, vecs[i].ez);
      chk($sformatf("row%0d last_zone", i), last_zone, vecs[i].el);
      chk($sformatf("row%0d last_vld", i), last_vld, vecs[i].elv);
      chk($sformatf("row%0d busy", i), busy,
          (vecs[i].es == 2 || vecs[i].es == 3 || vecs[i].es == 4) ? 1 : 0);
    end
    zone_vld = 1'b0; arm_done = 1'b0; enable = 1'b1;

    // Back-pressure: command held with constant zone until ready, then timeout.
    cmd_ready = 1'b0;
    repeat (4) frame(3'd6);
    chk("bp offer state", state_dbg, 2);
    chk("bp offer valid", cmd_valid, 1);
    chk("bp offer zone", cmd_zone, 6);
    for (int i = 0; i < 20; i++) begin
      zone_vld = i[0]; zone_in = 3'd1;
      step();
      chk($sformatf("bp hold%0d valid", i), cmd_valid, 1);
      chk($sformatf("bp hold%0d zone", i), cmd_zone, 6);
      chk($sformatf("bp hold%0d state", i), state_dbg, 2);
    end
    zone_vld = 1'b0;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("bp accept valid", cmd_valid, 0);
    chk("bp accept state", state_dbg, 3);
    chk("bp accept last_zone", last_zone, 6);
    repeat (99) step();
    chk("to pre state", state_dbg, 3);
    chk("to pre err", timeout_err, 0);
    err_clr = 1'b1;
    step();
    chk("to set err wins", timeout_err, 1);
    chk("to set state", state_dbg, 4);
    step();
    err_clr = 1'b0;
    chk("err_clr clears", timeout_err, 0);
    repeat (8) frame(3'd2);
    chk("to holdoff state", state_dbg, 4);
    step();
    chk("to holdoff exit", state_dbg, 0);

    // arm_done on the timeout cycle: done wins.
    cmd_ready = 1'b1;
    repeat (4) frame(3'd1);
    chk("race offer zone", cmd_zone, 1);
    step();
    cmd_ready = 1'b0;
    chk("race accept state", state_dbg, 3);
    repeat (99) step();
    arm_done = 1'b1;
    step();
    arm_done = 1'b0;
    chk("race state", state_dbg, 4);
    chk("race err", timeout_err, 0);
    repeat (8) frame(3'd0);
    step();
    chk("race holdoff exit", state_dbg, 0);

    // Asynchronous reset while a command is offered.
    repeat (4) frame(3'd2);
    chk("rst offer valid", cmd_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("rst async valid", cmd_valid, 0);
    chk("rst async state", state_dbg, 0);
    chk("rst async last_vld", last_vld, 0);
    chk("rst async busy", busy, 0);
    step();
    rst = 1'b0;
    step();
    chk("rst after state", state_dbg, 0);
    chk("rst after valid", cmd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zone_cmd_sequencer.md
Name: zone_cmd_sequencer

Overview:
- Sequences arm moves from the per-frame zone classification (3-bit zone, 8 zones: row bit [2], column [1:0]).
- Debounces the zone over consecutive frames, then issues one move command to the servo/arm controller over a valid/ready handshake.
- Waits for arm completion with a timeout, then applies a frame hold-off so motion blur is not re-classified.
- Sits between the zone classifier and the arm motion controller, in the camera clock domain.

Parameters:
- STABLE_FRAMES, 4: consecutive identical valid-zone frames required before issuing a command; legal range 1..15.
- HOLDOFF_FRAMES, 8: frames ignored after the move completes; legal range 0..255.
- TIMEOUT_CYCLES, 50000000: maximum cycles in WAIT_DONE (1 s at 50 MHz).
- TO_W, 26: width of the timeout counter; must satisfy 2^TO_W >= TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allows new tracking; low forces IDLE from TRACK only.
- zone_in  in  3  zone from the classifier.
- zone_vld  in  1  one-cycle pulse per frame when zone_in is valid.
- blob_present  in  1  black blob detected this frame; sampled with zone_vld.
- cmd_valid  out  1  command offer.
- cmd_zone  out  3  target zone; stable while cmd_valid is high.
- cmd_ready  in  1  arm controller accepts the command.
- arm_done  in  1  one-cycle pulse when the move completes.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky; set when WAIT_DONE exceeds TIMEOUT_CYCLES.
- last_zone  out  3  zone of the last accepted command.
- last_vld  out  1  last_zone is meaningful.
- busy  out  1  high in ISSUE, WAIT_DONE and HOLDOFF.
- state_dbg  out  3  encoded FSM state.

Behaviour:
- Reset values: state IDLE; cmd_valid 0; cmd_zone 0; timeout_err 0; last_zone 0; last_vld 0; busy 0; all counters 0. Reset asserted mid-operation drops cmd_valid asynchronously; any outstanding arm move is forgotten.
- State encoding: IDLE=0, TRACK=1, ISSUE=2, WAIT_DONE=3, HOLDOFF=4.
- IDLE, on zone_vld & blob_present & enable: cand <= zone_in, stab_cnt <= 1. Next state is TRACK, or ISSUE directly if STABLE_FRAMES == 1.
- TRACK, on zone_vld:
  - If !blob_present or !enable: go to IDLE and clear stab_cnt.
  - If zone_in == cand: increment stab_cnt, saturating at 15. When the incremented value equals STABLE_FRAMES:
    - if last_vld and cand == last_zone: stay in TRACK, no reissue (arm is already there);
    - otherwise go to ISSUE.
  - If zone_in != cand: cand <= zone_in, stab_cnt <= 1.
- TRACK with enable low and no zone_vld: go to IDLE on the next cycle.
- ISSUE:
  - cmd_valid = 1 and cmd_zone = cand, registered so valid is asserted the cycle after entry.
  - cmd_zone must not change while cmd_valid is high; cmd_valid is never withdrawn without a handshake, except on reset.
  - On cmd_valid & cmd_ready: cmd_valid <= 0, last_zone <= cand, last_vld <= 1, to_cnt <= 0, go to WAIT_DONE.
  - zone_vld is ignored.
- WAIT_DONE:
  - to_cnt increments each cycle.
  - arm_done: go to HOLDOFF, hold_cnt <= 0.
  - to_cnt == TIMEOUT_CYCLES-1 without arm_done: timeout_err <= 1, go to HOLDOFF.
  - arm_done in the same cycle as the timeout: done wins and timeout_err stays 0.
  - arm_done pulses in any other state are ignored.
- HOLDOFF:
  - Each zone_vld increments hold_cnt.
  - When hold_cnt reaches HOLDOFF_FRAMES, go to IDLE; HOLDOFF_FRAMES == 0 exits on the next cycle.
  - Frame content is not evaluated.
- timeout_err: err_clr clears it; err_clr in the same cycle as a set leaves it set. timeout_err does not block operation.
- Latency: the issuing frame's zone_vld to cmd_valid high is 1 cycle.

Decomposition:
- Shared package zone_pkg holds:
  - zone_t (3-bit);
  - the state enum;
  - the zone encoding constants (ZONE_COLS=4, ZONE_ROWS=2, row bit index 2).
- A natural sub-module is frame_debounce: cand/stab_cnt tracking with a stable pulse output, reusable for other per-frame classifications. Everything else stays in one FSM.

Test Plan:
- Default parameters; 4 zone_vld frames with zone 5 and blob_present, cmd_ready=1 -> cmd_valid for 1 cycle with cmd_zone=5; last_zone=5; last_vld=1; state WAIT_DONE.
- Frame zones 2,2,3,3,3,3 -> exactly one command, zone 3, issued on the 6th frame; none for zone 2.
- After a completed move to zone 3, four more zone-3 frames after HOLDOFF -> no new command; state stays TRACK.
- cmd_ready held low 20 cycles while in ISSUE -> cmd_valid stays high and cmd_zone stays constant; accepted on the first ready cycle.
- TIMEOUT_CYCLES=100, no arm_done -> timeout_err=1 at cycle 100 of WAIT_DONE, then HOLDOFF; err_clr clears it. Repeat with arm_done on cycle 100 -> timeout_err stays 0.
- Assert rst while cmd_valid is high -> cmd_valid is 0 immediately (before the next clk edge); state IDLE; last_vld=0.
